// File: rtl/exe_issue_ctrl.sv
// Issue controller for a multi-cycle execution unit: buffers decoded ops in a FIFO,
// launches one op at a time with a start pulse, and hands the result to writeback.
module exe_issue_ctrl #(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             exe_start,
  output logic [2:0]       exe_op,
  output logic [31:0]      exe_a,
  output logic [31:0]      exe_b,
  input  logic             exe_valid,
  input  logic [31:0]      exe_result,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [31:0]      wb_result,
  output logic [TAG_W-1:0] wb_tag,
  output logic             timeout_err,
  output logic             busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int WD_W  = $clog2(TIMEOUT);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_WB   = 2'd2;

  logic [1:0]       state_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [WD_W-1:0]  wd_cnt_r;
  logic             exe_start_r;
  logic [2:0]       exe_op_r;
  logic [31:0]      exe_a_r;
  logic [31:0]      exe_b_r;
  logic [TAG_W-1:0] issue_tag_r;
  logic             wb_valid_r;
  logic [31:0]      wb_result_r;
  logic [TAG_W-1:0] wb_tag_r;
  logic             timeout_err_r;

  logic [2:0]       fifo_op_r  [DEPTH];
  logic [31:0]      fifo_a_r   [DEPTH];
  logic [31:0]      fifo_b_r   [DEPTH];
  logic [TAG_W-1:0] fifo_tag_r [DEPTH];

  logic full_s;
  logic empty_s;
  logic push_s;
  logic pop_s;

  // Fullness comes from the registered count only, so a same-cycle pop never frees a slot.
  assign full_s  = (count_r == CNT_W'(DEPTH));
  assign empty_s = (count_r == {CNT_W{1'b0}});
  assign push_s  = in_valid && !full_s;
  assign pop_s   = (state_r == ST_IDLE) && !empty_s;

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      if (push_s && !pop_s) begin
        count_r <= count_r + CNT_W'(1);
      end else if (!push_s && pop_s) begin
        count_r <= count_r - CNT_W'(1);
      end
    end
  end

  // FIFO storage; contents are don't-care while the slot is empty
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_op_r[wr_ptr_r]  <= in_op;
      fifo_a_r[wr_ptr_r]   <= in_a;
      fifo_b_r[wr_ptr_r]   <= in_b;
      fifo_tag_r[wr_ptr_r] <= in_tag;
    end
  end

  // Issue / wait / writeback sequencing with watchdog
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      wd_cnt_r      <= {WD_W{1'b0}};
      exe_start_r   <= 1'b0;
      exe_op_r      <= 3'd0;
      exe_a_r       <= 32'd0;
      exe_b_r       <= 32'd0;
      issue_tag_r   <= {TAG_W{1'b0}};
      wb_valid_r    <= 1'b0;
      wb_result_r   <= 32'd0;
      wb_tag_r      <= {TAG_W{1'b0}};
      timeout_err_r <= 1'b0;
    end else begin
      exe_start_r   <= 1'b0;
      timeout_err_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (!empty_s) begin
            exe_op_r    <= fifo_op_r[rd_ptr_r];
            exe_a_r     <= fifo_a_r[rd_ptr_r];
            exe_b_r     <= fifo_b_r[rd_ptr_r];
            issue_tag_r <= fifo_tag_r[rd_ptr_r];
            exe_start_r <= 1'b1;
            wd_cnt_r    <= {WD_W{1'b0}};
            state_r     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // A valid coinciding with the start pulse belongs to no op of ours.
          if (!exe_start_r && exe_valid) begin
            wb_result_r <= exe_result;
            wb_tag_r    <= issue_tag_r;
            wb_valid_r  <= 1'b1;
            state_r     <= ST_WB;
          end else if (wd_cnt_r == WD_W'(TIMEOUT - 1)) begin
            timeout_err_r <= 1'b1;
            state_r       <= ST_IDLE;
          end else begin
            wd_cnt_r <= wd_cnt_r + WD_W'(1);
          end
        end
        ST_WB: begin
          if (wb_ready) begin
            wb_valid_r <= 1'b0;
            state_r    <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready    = !full_s;
  assign busy        = (state_r != ST_IDLE) || !empty_s;
  assign exe_start   = exe_start_r;
  assign exe_op      = exe_op_r;
  assign exe_a       = exe_a_r;
  assign exe_b       = exe_b_r;
  assign wb_valid    = wb_valid_r;
  assign wb_result   = wb_result_r;
  assign wb_tag      = wb_tag_r;
  assign timeout_err = timeout_err_r;

endmodule
